// File: rtl/pilot_tone_pkg.sv
// Pilot-tone sequencer shared types and constants.
// State encodings, nominal patterns and tick conversion helpers.
package pilot_tone_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WARN      = 3'd1,
    STABILIZE = 3'd2,
    STABLE    = 3'd3,
    HOLD      = 3'd4,
    SHUTDOWN  = 3'd5,
    AWAIT     = 3'd6,
    BEAM      = 3'd7
  } ptState_t;

  localparam logic [7:0] PATTERN_OFF        = 8'h00;
  localparam logic [7:0] PATTERN_CONTINUOUS = 8'h55;
  localparam logic [7:0] PATTERN_SINGLE     = 8'h88;

  localparam longint unsigned EVR_CLOCK_RATE = 125_000_000;

  function automatic logic [31:0] msToTicks(
    input int unsigned ms
  );
    return 32'(64'(ms) * EVR_CLOCK_RATE / 64'd1000);
  endfunction

  function automatic logic [31:0] usToTicks(
    input int unsigned us
  );
    return 32'(64'(us) * EVR_CLOCK_RATE / 64'd1000000);
  endfunction

endpackage

// File: rtl/pilot_tone_phase_timer.sv
// Loadable phase down-counter; a phase of length D lasts max(D,1) cycles.
// done is high while the count sits at zero.
module pilot_tone_phase_timer #(
  parameter int CW = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] dur,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= (dur == '0) ? '0 : dur - CW'(1);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pilot_tone_sequencer.sv
// Multi-channel programmable pilot-tone sequencer in the evrClk domain.
// Drives per-channel SERDES pattern words through warn/tone/shutdown phases.
module pilot_tone_sequencer
  import pilot_tone_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int PW     = 8,
  parameter int CW     = 27,
  parameter int MISS_W = 8
) (
  input  logic              evrClk,
  input  logic              evrReset,
  input  logic              enable,
  input  logic              simulate,
  input  logic              usePulse,
  input  logic [NCH-1:0]    chanMask,
  input  logic              trigger,
  input  logic              pulseStrobe,
  input  logic              abort,
  input  logic [PW-1:0]     contPattern,
  input  logic [PW-1:0]     pulsePattern,
  input  logic [CW-1:0]     durWarn,
  input  logic [CW-1:0]     durStabilize,
  input  logic [CW-1:0]     durStable,
  input  logic [CW-1:0]     durHold,
  input  logic [CW-1:0]     durShutdown,
  input  logic [CW-1:0]     durAwait,
  input  logic [CW-1:0]     durBeam,
  output logic [NCH*PW-1:0] ptPattern,
  output logic              ptWarning,
  output logic              ptStable,
  output logic              busy,
  output logic [2:0]        stateCode,
  output logic [MISS_W-1:0] missedCount
);

  ptState_t state, nextState;

  logic trigD, start, accept, kill;
  logic load, done;
  logic [CW-1:0] loadDur;

  logic [CW-1:0]  shDur [8];
  logic [PW-1:0]  contL, pulseL;
  logic           usePulseL, simL;
  logic [NCH-1:0] maskL;

  logic              warnD, stableD, tone;
  logic [PW-1:0]     word;
  logic [NCH*PW-1:0] patD;

  assign start  = trigger & ~trigD;
  assign accept = start & enable & ~abort & (state == IDLE);
  assign kill   = (state != IDLE) & (abort | ~enable);

  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      state <= IDLE;
      trigD <= 1'b0;
    end else begin
      state <= nextState;
      trigD <= trigger;
    end
  end

  always_comb begin
    nextState = state;
    if (kill) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (accept) nextState = WARN;
        WARN:      if (done) nextState = STABILIZE;
        STABILIZE: if (done) nextState = STABLE;
        STABLE:    if (done) nextState = HOLD;
        HOLD:      if (done) nextState = SHUTDOWN;
        SHUTDOWN:  if (done) nextState = simL ? AWAIT : IDLE;
        AWAIT:     if (done) nextState = BEAM;
        BEAM:      if (done) nextState = IDLE;
        default:   nextState = IDLE;
      endcase
    end
  end

  // WARN is entered on the same edge that fills the shadow bank
  assign load    = (nextState != state);
  assign loadDur = (state == IDLE) ? durWarn : shDur[nextState];

  pilot_tone_phase_timer #(
    .CW(CW)
  ) uTimer (
    .clk (evrClk),
    .rst (evrReset),
    .load(load),
    .dur (loadDur),
    .done(done)
  );

  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      for (int i = 0; i < 8; i++) shDur[i] <= '0;
      contL     <= '0;
      pulseL    <= '0;
      usePulseL <= 1'b0;
      simL      <= 1'b0;
      maskL     <= '0;
    end else if (accept) begin
      shDur[0]  <= '0;
      shDur[1]  <= durWarn;
      shDur[2]  <= durStabilize;
      shDur[3]  <= durStable;
      shDur[4]  <= durHold;
      shDur[5]  <= durShutdown;
      shDur[6]  <= durAwait;
      shDur[7]  <= durBeam;
      contL     <= contPattern;
      pulseL    <= pulsePattern;
      usePulseL <= usePulse;
      simL      <= simulate;
      maskL     <= chanMask;
    end
  end

  always_comb begin
    warnD   = nextState inside {WARN, STABILIZE, STABLE, HOLD, SHUTDOWN};
    stableD = (nextState == STABLE);
    tone    = nextState inside {STABILIZE, STABLE, HOLD, BEAM};
    word    = usePulseL ? (pulseStrobe ? pulseL : PW'(PATTERN_OFF))
                        : contL;
  end

  for (genvar k = 0; k < NCH; k++) begin : gChan
    assign patD[k*PW +: PW] = (tone & maskL[k]) ? word : '0;
  end

  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      ptPattern <= '0;
      ptWarning <= 1'b0;
      ptStable  <= 1'b0;
    end else begin
      ptPattern <= patD;
      ptWarning <= warnD;
      ptStable  <= stableD;
    end
  end

  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      missedCount <= '0;
    end else if (start & ~accept & (missedCount != '1)) begin
      missedCount <= missedCount + MISS_W'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign stateCode = state;

endmodule

// File: tb/tb_pilot_tone_sequencer.sv
// Scoreboard bench for pilot_tone_sequencer.
// Expected per-cycle traces are queued at trigger time and popped each cycle.
module tb_pilot_tone_sequencer;

  localparam int NCH = 4, PW = 8, CW = 27, MISS_W = 8;

  logic evrClk = 0, evrReset = 1;
  logic enable = 1, simulate = 0, usePulse = 0;
  logic [NCH-1:0] chanMask = 4'b0101;
  logic trigger = 0, pulseStrobe = 0, abort = 0;
  logic [PW-1:0] contPattern = 8'h55, pulsePattern = 8'h88;
  logic [CW-1:0] durWarn = 3, durStabilize = 3, durStable = 3;
  logic [CW-1:0] durHold = 3, durShutdown = 3, durAwait = 3, durBeam = 3;
  logic [NCH*PW-1:0] ptPattern;
  logic ptWarning, ptStable, busy;
  logic [2:0] stateCode;
  logic [MISS_W-1:0] missedCount;

  pilot_tone_sequencer #(
    .NCH(NCH), .PW(PW), .CW(CW), .MISS_W(MISS_W)
  ) dut (
    .evrClk(evrClk), .evrReset(evrReset), .enable(enable),
    .simulate(simulate), .usePulse(usePulse), .chanMask(chanMask),
    .trigger(trigger), .pulseStrobe(pulseStrobe), .abort(abort),
    .contPattern(contPattern), .pulsePattern(pulsePattern),
    .durWarn(durWarn), .durStabilize(durStabilize),
    .durStable(durStable), .durHold(durHold),
    .durShutdown(durShutdown), .durAwait(durAwait),
    .durBeam(durBeam), .ptPattern(ptPattern),
    .ptWarning(ptWarning), .ptStable(ptStable), .busy(busy),
    .stateCode(stateCode), .missedCount(missedCount)
  );

  always #5 evrClk = ~evrClk;

  typedef struct {
    logic [2:0] st;
    logic w;
    logic s;
    logic tone;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int nChecks = 0, nFails = 0, expMiss = 0;
  logic [PW-1:0] lCp, lPp;
  logic lPulse, ps;
  logic [NCH-1:0] lMask;
  logic [NCH*PW-1:0] ep;

  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask

  task automatic pushPhase(input logic [2:0] st, input logic [CW-1:0] d);
    exp_t e;
    e.st = st;
    e.w = (st >= 3'd1) && (st <= 3'd5);
    e.s = (st == 3'd3);
    e.tone = (st == 3'd2) || (st == 3'd3) || (st == 3'd4) || (st == 3'd7);
    repeat ((d == 0) ? 1 : int'(d)) sb.push_back(e);
  endtask

  // Queue the whole expected trace and raise trigger for the next edge
  task automatic startSeq();
    exp_t e;
    lCp = contPattern; lPp = pulsePattern;
    lPulse = usePulse; lMask = chanMask;
    pushPhase(3'd1, durWarn);
    pushPhase(3'd2, durStabilize);
    pushPhase(3'd3, durStable);
    pushPhase(3'd4, durHold);
    pushPhase(3'd5, durShutdown);
    if (simulate) begin
      pushPhase(3'd6, durAwait);
      pushPhase(3'd7, durBeam);
    end
    e = '{st: 3'd0, w: 1'b0, s: 1'b0, tone: 1'b0};
    sb.push_back(e);
    trigger = 1'b1;
  endtask

  function automatic logic [NCH*PW-1:0] expPat(input logic tn, input logic p);
    logic [PW-1:0] w;
    expPat = '0;
    w = lPulse ? (p ? lPp : 8'h00) : lCp;
    for (int k = 0; k < NCH; k++)
      if (tn && lMask[k]) expPat[k*PW +: PW] = w;
  endfunction

  task automatic test_reset();
    evrReset = 1'b1;
    tick(); tick();
    nChecks++;
    if ({ptPattern, ptWarning, ptStable, busy, stateCode, missedCount} !== '0) begin
      nFails++;
      $display("FAIL reset: got pat=%h w=%b s=%b busy=%b st=%0d miss=%0d, expected all 0",
               ptPattern, ptWarning, ptStable, busy, stateCode, missedCount);
    end
    evrReset = 1'b0;
    expMiss = 0;
    tick();
  endtask

  task automatic test_continuous();
    startSeq();
    while (sb.size() > 0) begin
      ex = sb.pop_front(); ps = pulseStrobe;
      tick(); trigger = 1'b0;
      contPattern = 8'hA5; durHold = 1;
      ep = expPat(ex.tone, ps);
      nChecks++;
      if ({stateCode, ptWarning, ptStable, busy, ptPattern} !==
          {ex.st, ex.w, ex.s, ex.st != 3'd0, ep}) begin
        nFails++;
        $display("FAIL continuous: got st=%0d w=%b s=%b busy=%b pat=%h, expected st=%0d w=%b s=%b pat=%h",
                 stateCode, ptWarning, ptStable, busy, ptPattern, ex.st, ex.w, ex.s, ep);
      end
    end
    contPattern = 8'h55; durHold = 3;
  endtask

  task automatic test_pulse();
    usePulse = 1; chanMask = 4'b1111;
    {durWarn, durStabilize, durStable, durHold, durShutdown} = {5{27'd4}};
    startSeq();
    while (sb.size() > 0) begin
      ex = sb.pop_front(); ps = pulseStrobe;
      tick(); trigger = 1'b0;
      pulseStrobe = ~pulseStrobe;
      ep = expPat(ex.tone, ps);
      nChecks++;
      if ({stateCode, ptWarning, ptStable, busy, ptPattern} !==
          {ex.st, ex.w, ex.s, ex.st != 3'd0, ep}) begin
        nFails++;
        $display("FAIL pulse: got st=%0d w=%b s=%b busy=%b pat=%h, expected st=%0d w=%b s=%b pat=%h",
                 stateCode, ptWarning, ptStable, busy, ptPattern, ex.st, ex.w, ex.s, ep);
      end
    end
    usePulse = 0; pulseStrobe = 0; chanMask = 4'b0101;
  endtask

  task automatic test_simulate_and_zero();
    for (int run = 0; run < 3; run++) begin
      if (run == 0) begin
        simulate = 1; durAwait = 2; durBeam = 5;
        {durWarn, durStabilize, durStable, durHold, durShutdown} = {5{27'd3}};
      end else begin
        simulate = (run == 2); durAwait = 0; durBeam = 0;
        {durWarn, durStabilize, durStable, durHold, durShutdown} = '0;
      end
      startSeq();
      while (sb.size() > 0) begin
        ex = sb.pop_front(); ps = pulseStrobe;
        tick(); trigger = 1'b0;
        ep = expPat(ex.tone, ps);
        nChecks++;
        if ({stateCode, ptWarning, ptStable, busy, ptPattern} !==
            {ex.st, ex.w, ex.s, ex.st != 3'd0, ep}) begin
          nFails++;
          $display("FAIL simzero run %0d: got st=%0d w=%b s=%b busy=%b pat=%h, expected st=%0d w=%b s=%b pat=%h",
                   run, stateCode, ptWarning, ptStable, busy, ptPattern, ex.st, ex.w, ex.s, ep);
        end
      end
    end
    simulate = 0;
    {durWarn, durStabilize, durStable, durHold, durShutdown} = {5{27'd3}};
  endtask

  task automatic test_abort();
    startSeq();
    for (int i = 0; i < 8; i++) begin
      ex = sb.pop_front(); ps = pulseStrobe;
      tick(); trigger = 1'b0;
      ep = expPat(ex.tone, ps);
      nChecks++;
      if ({stateCode, ptWarning, ptStable, ptPattern} !== {ex.st, ex.w, ex.s, ep}) begin
        nFails++;
        $display("FAIL abort prefix: got st=%0d pat=%h, expected st=%0d pat=%h",
                 stateCode, ptPattern, ex.st, ep);
      end
    end
    sb.delete();
    abort = 1; tick(); abort = 0;
    nChecks++;
    if ({stateCode, ptWarning, ptStable, busy, ptPattern} !== '0) begin
      nFails++;
      $display("FAIL abort: got st=%0d w=%b s=%b pat=%h, expected all 0",
               stateCode, ptWarning, ptStable, ptPattern);
    end
    tick();
    startSeq();
    repeat (5) begin tick(); trigger = 1'b0; end
    sb.delete();
    enable = 0; tick();
    nChecks++;
    if ({stateCode, ptWarning, busy, ptPattern} !== '0) begin
      nFails++;
      $display("FAIL enable drop: got st=%0d pat=%h, expected 0", stateCode, ptPattern);
    end
    trigger = 1; tick(); trigger = 0; tick();
    expMiss++;
    nChecks++;
    if (stateCode !== 3'd0 || missedCount !== 8'(expMiss)) begin
      nFails++;
      $display("FAIL trigger while disabled: got st=%0d miss=%0d, expected st=0 miss=%0d",
               stateCode, missedCount, expMiss);
    end
    enable = 1; tick();
    abort = 1; trigger = 1; tick(); abort = 0; trigger = 0; tick();
    expMiss++;
    nChecks++;
    if (stateCode !== 3'd0 || missedCount !== 8'(expMiss)) begin
      nFails++;
      $display("FAIL start with abort: got st=%0d miss=%0d, expected st=0 miss=%0d",
               stateCode, missedCount, expMiss);
    end
  endtask

  task automatic test_missed();
    int edges = 0, i = 0;
    {durWarn, durStabilize, durStable, durHold, durShutdown} = {5{27'd150}};
    startSeq();
    while (sb.size() > 0) begin
      ex = sb.pop_front(); ps = pulseStrobe;
      tick();
      ep = expPat(ex.tone, ps);
      nChecks++;
      if ({stateCode, ptWarning, ptStable, busy, ptPattern} !==
          {ex.st, ex.w, ex.s, ex.st != 3'd0, ep}) begin
        nFails++;
        $display("FAIL missed seq cyc %0d: got st=%0d pat=%h, expected st=%0d pat=%h",
                 i, stateCode, ptPattern, ex.st, ep);
      end
      nChecks++;
      if (missedCount !== 8'(expMiss)) begin
        nFails++;
        $display("FAIL missed count cyc %0d: got %0d, expected %0d", i, missedCount, expMiss);
      end
      trigger = (i % 2 == 1) && (edges < 300);
      if (trigger) begin
        edges++;
        expMiss = (expMiss < 255) ? expMiss + 1 : 255;
      end
      i++;
    end
    nChecks++;
    if (missedCount !== 8'd255) begin
      nFails++;
      $display("FAIL missed saturate: got %0d, expected 255", missedCount);
    end
    {durWarn, durStabilize, durStable, durHold, durShutdown} = {5{27'd3}};
  endtask

  task automatic test_reset_mid_hold();
    startSeq();
    repeat (11) begin tick(); trigger = 1'b0; end
    sb.delete();
    nChecks++;
    if (stateCode !== 3'd4) begin
      nFails++;
      $display("FAIL reach hold: got st=%0d, expected 4", stateCode);
    end
    #2 evrReset = 1; #1;
    nChecks++;
    if ({ptPattern, ptWarning, ptStable, busy, stateCode, missedCount} !== '0) begin
      nFails++;
      $display("FAIL async reset: got pat=%h w=%b s=%b st=%0d miss=%0d, expected all 0",
               ptPattern, ptWarning, ptStable, stateCode, missedCount);
    end
    tick(); evrReset = 0; expMiss = 0; tick();
    startSeq();
    while (sb.size() > 0) begin
      ex = sb.pop_front(); ps = pulseStrobe;
      tick(); trigger = 1'b0;
      ep = expPat(ex.tone, ps);
      nChecks++;
      if ({stateCode, ptWarning, ptStable, busy, ptPattern} !==
          {ex.st, ex.w, ex.s, ex.st != 3'd0, ep}) begin
        nFails++;
        $display("FAIL post reset: got st=%0d w=%b s=%b pat=%h, expected st=%0d w=%b s=%b pat=%h",
                 stateCode, ptWarning, ptStable, ptPattern, ex.st, ex.w, ex.s, ep);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_pulse();
    test_simulate_and_zero();
    test_abort();
    test_missed();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pilot_tone_sequencer.md
Name: pilot_tone_sequencer

Overview:
- Multi-channel, runtime-programmable successor to the fixed-timing pilot-tone controller.
- Sequences warn -> tone on -> stable -> hold -> shutdown -> optional simulated beam, with per-phase durations supplied as register inputs.
- Drives NCH independent parallel pattern words to external per-channel SERDES; contains no MMCM or SERDES itself.
- Sits in the evrClk domain between the register bank or EVR trigger decode and the pilot-tone SERDES instances.

Parameters:
- NCH, 4, number of pilot-tone output channels.
- PW, 8, pattern word width (SERDES parallel width).
- CW, 27, duration counter width in ticks; default covers 1 s at 125 MHz.
- MISS_W, 8, width of the missed-trigger counter.

Ports:
- evrClk  in  1  event clock; all logic and ports are in this domain.
- evrReset  in  1  reset; one clock, asynchronous, active-high.
- enable  in  1  synchronous master enable.
- simulate  in  1  appends simulated-beam phases when set.
- usePulse  in  1  1 = pulse mode, 0 = continuous mode.
- chanMask  in  NCH  per-channel enable.
- trigger  in  1  start request, rising-edge sensitive.
- pulseStrobe  in  1  selects pulse pattern vs off in pulse mode.
- abort  in  1  synchronous abort.
- contPattern  in  PW  continuous pattern (nominal 8'h55).
- pulsePattern  in  PW  pulse pattern (nominal 8'h88).
- durWarn, durStabilize, durStable, durHold, durShutdown, durAwait, durBeam  in  CW each  phase lengths in ticks.
- ptPattern  out  NCH*PW  channel k occupies bits [k*PW +: PW].
- ptWarning  out  1  warning flag.
- ptStable  out  1  tone-stable flag.
- busy  out  1  high whenever state != IDLE.
- stateCode  out  3  current state encoding.
- missedCount  out  MISS_W  saturating count of ignored triggers.

Behaviour:
- Reset (async assert, release synchronous to evrClk): state IDLE; all outputs 0; trigger edge register 0.
- States and encodings: IDLE=0, WARN=1, STABILIZE=2, STABLE=3, HOLD=4, SHUTDOWN=5, AWAIT=6, BEAM=7.
- Edge detect: trig_d registered each cycle; start = trigger & ~trig_d.
- IDLE:
  - On start & enable at cycle t: latch all dur*, patterns, usePulse, simulate and chanMask into shadow registers.
  - At t+1: state=WARN, ptWarning=1, busy=1.
- Phase length: each phase lasts exactly max(D,1) cycles, D = latched duration. Counter loads max(D,1)-1 on entry and exits when it reaches 0.
- Transitions:
  - WARN -> STABILIZE -> STABLE -> HOLD -> SHUTDOWN.
  - SHUTDOWN -> AWAIT if latched simulate, else -> IDLE.
  - AWAIT -> BEAM -> IDLE.
- Flags:
  - ptStable is 1 exactly during STABLE.
  - ptWarning is 1 from WARN through SHUTDOWN inclusive.
  - ptWarning and ptStable are 0 during AWAIT and BEAM.
- Patterns (registered, visible the cycle the state becomes visible):
  - In STABILIZE, STABLE, HOLD and BEAM, each channel outputs:
    - continuous mode: contPattern;
    - pulse mode: pulseStrobe ? pulsePattern : 0, evaluated every cycle with one cycle of latency.
  - In IDLE, WARN, SHUTDOWN and AWAIT, all channels output 0.
  - Channels whose latched mask bit is 0 always output 0.
- Trigger while busy, or trigger while enable=0 in IDLE: ignored, and missedCount increments, saturating at all-ones. missedCount clears only on reset.
- abort, or enable falling while busy: next cycle state=IDLE, all patterns 0, both flags 0. The abort takes priority over a same-cycle phase transition.
- A start coincident with abort in IDLE is ignored and counted as missed.
- Register changes while busy have no effect until the next start.

Decomposition:
- Package pilot_tone_pkg:
  - state encodings;
  - nominal pattern constants PATTERN_OFF=8'h00, PATTERN_CONTINUOUS=8'h55, PATTERN_SINGLE=8'h88;
  - a helper for converting ms/us to ticks at EVR_CLOCK_RATE.
- One sub-module, pilot_tone_phase_timer: loadable down-counter of width CW with load value max(D,1)-1 and a done pulse.
- The per-channel pattern mux is a generate loop, not a module.

Test Plan:
- All durations 3, simulate=0, continuous, mask=4'b0101, trigger edge at t:
  - ptWarning rises at t+1 and stays high 15 cycles;
  - ptStable is high cycles t+7..t+9;
  - channels 0 and 2 carry 8'h55 during t+4..t+12;
  - channels 1 and 3 stay 0;
  - busy falls at t+16.
- Pulse mode, pulseStrobe toggled every cycle, durations 4: during tone phases each channel word alternates 8'h88/8'h00, lagging pulseStrobe by 1 cycle.
- simulate=1, durAwait=2, durBeam=5: after SHUTDOWN, 2 cycles with output 0 and flags 0, then 5 cycles of contPattern, then IDLE.
- Durations all 0: every phase lasts 1 cycle, so the full sequence is 5 cycles, plus 2 more when simulate=1.
- abort pulsed mid-STABLE: next cycle stateCode=0, patterns 0, ptStable=0, ptWarning=0.
- 300 trigger edges while busy with MISS_W=8: missedCount=255 (saturated); the sequence in progress is unaffected.
- Reset asserted mid-HOLD: all outputs go to 0 immediately without waiting for a clock edge; after release the next trigger starts a fresh sequence.
